// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit side: frame-config layout and
// scheduler state encodings.
package uart_pkg;

    localparam int CONF_W          = 5;
    localparam int CONF_PARITY_BIT = 0;
    localparam int CONF_STOP_LSB   = 1;
    localparam int CONF_DATA_LSB   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10
    } sched_state_e;

    // Builds a frame config word {data_size, stop_size, parity_en}.
    function automatic logic [CONF_W-1:0] conf_pack(
        input logic [1:0] data_size,
        input logic [1:0] stop_size,
        input logic       parity_en
    );
        return {data_size, stop_size, parity_en};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr_i (wrapping) wins; returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmit engine from NUM_REQ byte
// requesters; one frame in flight at a time, bounded by a WAIT timeout.
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CONF_W         = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [CONF_W-1:0]          conf_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_en_o,
    output logic                       tx_start_o,
    output logic [CONF_W-1:0]          tx_conf_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_done_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       timeout_o,
    output logic [1:0]                 dbg_state_o
);

    import uart_pkg::sched_state_e;
    import uart_pkg::ST_IDLE;
    import uart_pkg::ST_START;
    import uart_pkg::ST_WAIT;

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    sched_state_e      state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic              tx_en_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic               accept;
    logic               expire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Handshake: a byte moves when req_valid_i[k] & req_ready_o[k] at a clock
    // edge. Ready is offered only in IDLE with enable_i high, to one requester,
    // and never waits on valid staying up, so a requester may withdraw freely.
    assign accept = (state_q == ST_IDLE) && enable_i && arb_any;
    assign expire = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        conf_d      = conf_q;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
        timeout_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_o = arb_grant;
                    data_d      = req_data_i[{arb_idx, 3'b000} +: 8];
                    conf_d      = conf_i;
                    grant_id_d  = arb_idx;
                    ptr_d       = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                tx_start_o = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (tx_done_i) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    timeout_o = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            conf_q     <= '0;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            conf_q     <= conf_d;
            tx_en_q    <= enable_i;
        end
    end

    assign tx_en_o     = tx_en_q;
    assign tx_data_o   = data_q;
    assign tx_conf_o   = conf_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected frames are queued as stimulus is
// issued and a negedge monitor checks each tx_start_o against the queue.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int TO = 128;
    localparam int EW = 8 + CONF_W + 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              enable;
    logic [CONF_W-1:0] conf;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              tx_en;
    logic              tx_start;
    logic [CONF_W-1:0] tx_conf;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout;
    logic [1:0]        dbg_state;

    uart_tx_sched #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .CONF_W         (CONF_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .conf_i      (conf),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .tx_en_o     (tx_en),
        .tx_start_o  (tx_start),
        .tx_conf_o   (tx_conf),
        .tx_data_o   (tx_data),
        .tx_done_i   (tx_done),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .timeout_o   (timeout),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] frame(input logic [7:0] d, input logic [CONF_W-1:0] c,
                                            input logic [1:0] id);
        return {d, c, id};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_start: got grant %0d data 0x%0h, expected no frame",
                         grant_id, tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("start_frame", {tx_data, tx_conf, grant_id}, mon_exp);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) seen = 1'b1;
        end
        check("start_seen", 32'(seen), 32'd1);
    endtask

    // Called at the START-cycle negedge; done is driven in WAIT cycle n.
    task automatic finish_frame(input int n);
        tick();
        repeat (n - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int first_to;
    int n_to;

    initial begin
        rst = 1'b1; enable = 1'b0; conf = '0; req_valid = '0; req_data = '0; tx_done = 1'b0;
        repeat (3) tick();
        to_neg();
        check("rst_start", 32'(tx_start), 0);
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_conf", 32'(tx_conf), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst = 1'b0;

        // single requester, done at +100
        tick();
        enable = 1'b1; conf = 5'b11001; req_data[7:0] = 8'h55; req_valid = 4'b0001;
        exp_q.push_back(frame(8'h55, 5'b11001, 2'd0));
        to_neg();
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        to_neg();
        check("t1_start_latency", 32'(tx_start), 1);
        check("t1_ready_start", 32'(req_ready), 0);
        check("t1_tx_en", 32'(tx_en), 1);
        tick();
        repeat (98) tick();
        to_neg();
        check("t1_busy_wait", 32'(busy), 1);
        check("t1_state_wait", 32'(dbg_state), 32'(ST_WAIT));
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        to_neg();
        check("t1_idle_after_done", 32'(busy), 0);

        // fairness from a freshly reset pointer
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        conf = 5'b01100; req_data = 32'hA3A2A1A0; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(frame(8'hA0 + 8'(k % 4), 5'b01100, 2'(k % 4)));
        end
        for (int k = 0; k < 5; k++) begin
            wait_start();
            finish_frame(3);
            if (k == 4) req_valid = '0;
            to_neg();
            check("rr_next_ready", 32'(req_ready), (k == 4) ? 32'h0 : (32'h1 << ((k + 1) % 4)));
        end

        // timeout with immediate re-grant of the same requester
        tick();
        req_data[23:16] = 8'h3C; req_valid = 4'b0100;
        exp_q.push_back(frame(8'h3C, 5'b01100, 2'd2));
        exp_q.push_back(frame(8'h3C, 5'b01100, 2'd2));
        wait_start();
        first_to = -1; n_to = 0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            to_neg();
            if (timeout === 1'b1) begin
                n_to++;
                if (first_to < 0) first_to = i;
            end
        end
        check("to_offset", 32'(first_to), 32'(TO));
        tick();
        to_neg();
        check("to_regrant_ready", 32'(req_ready), 32'h4);
        check("to_pulse_width", 32'(n_to + int'(timeout)), 32'd1);
        tick();
        req_valid = '0;
        wait_start();
        finish_frame(2);

        // done on the expiry cycle: done wins
        tick();
        req_data[31:24] = 8'hC3; req_valid = 4'b1000;
        exp_q.push_back(frame(8'hC3, 5'b01100, 2'd3));
        wait_start();
        req_valid = '0;
        repeat (TO - 1) tick();
        tick();
        tx_done = 1'b1;
        to_neg();
        check("coll_no_timeout", 32'(timeout), 0);
        tick();
        tx_done = 1'b0;
        to_neg();
        check("coll_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("coll_no_timeout_after", 32'(timeout), 0);
        tick(); tx_done = 1'b1;
        tick(); tx_done = 1'b0;
        to_neg();
        check("idle_done_ignored", 32'(busy), 0);

        // enable dropped mid-frame
        tick();
        conf = 5'b10110; req_data[15:8] = 8'h5A; req_valid = 4'b0010;
        exp_q.push_back(frame(8'h5A, 5'b10110, 2'd1));
        wait_start();
        tick();
        enable = 1'b0; conf = 5'b00000; req_valid = 4'b1111;
        to_neg();
        check("en_tx_en_hold", 32'(tx_en), 1);
        tick();
        to_neg();
        check("en_tx_en_fall", 32'(tx_en), 0);
        tick(); tx_done = 1'b1;
        tick(); tx_done = 1'b0;
        to_neg();
        check("en_done_accepted", 32'(busy), 0);
        check("en_no_ready", 32'(req_ready), 0);
        check("en_conf_hold", 32'(tx_conf), 32'h16);
        check("en_data_hold", 32'(tx_data), 32'h5A);
        repeat (3) begin
            tick();
            to_neg();
            check("en_no_grant", 32'(busy), 0);
        end
        tick();
        enable = 1'b1;
        exp_q.push_back(frame(8'h3C, 5'b00000, 2'd2));
        to_neg();
        check("reen_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        wait_start();
        finish_frame(2);

        // reset in the middle of WAIT
        tick();
        req_valid = 4'b0010;
        exp_q.push_back(frame(8'h5A, 5'b00000, 2'd1));
        wait_start();
        tick();
        req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        to_neg();
        check("mrst_start", 32'(tx_start), 0);
        check("mrst_tx_en", 32'(tx_en), 0);
        check("mrst_data", 32'(tx_data), 0);
        check("mrst_grant", 32'(grant_id), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick(); tx_done = 1'b1;
        tick(); tx_done = 1'b0;
        to_neg();
        check("mrst_stray_done", 32'(busy), 0);
        tick();
        conf = 5'b01011; req_valid = 4'b1111;
        exp_q.push_back(frame(8'hA0, 5'b01011, 2'd0));
        to_neg();
        check("mrst_ptr_zero", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_start();
        finish_frame(1);

        repeat (4) tick();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
